spi_tx_serializer: RTL and testbench
====================================

Name: spi_tx_serializer

Overview:
- Transmit half of the SPI-style link. Takes 16-bit words strobed off the Cypress FD bus and buffers them in a small FIFO.
- Serializes each word MSB-first onto TX_DATA, marking byte ends with TX_LOAD and message ends with TX_STOP.
- One instance per SPI channel. TX_CLK is driven externally from the same CLK, so downstream receivers sample on the opposite edge.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW words.
- GAP_CYCLES, 2: idle bit-times (TX_DATA=0) inserted after every byte; legal range 0..15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- DATA  in  16  word from FD; DATA[15:8] sent first.
- ENA  in  1  write strobe; DATA/LAST/ODD captured when ENA=1.
- LAST  in  1  word is the last of its message.
- ODD  in  1  valid only with LAST; only DATA[15:8] is sent.
- TX_DATA  out  1  serial data, MSB-first.
- TX_LOAD  out  1  high during the final bit of each byte.
- TX_STOP  out  1  high during the final bit of a message's last byte.
- BUSY  out  1  FIFO non-empty or shifter not IDLE.
- FULL  out  1  FIFO full.
- OVERFLOW  out  1  sticky; set when ENA arrives while FULL.

Behaviour:
- Reset:
  - All outputs are 0; FIFO is emptied; FSM goes to IDLE.
  - Reset mid-byte aborts immediately: no TX_LOAD/TX_STOP pulse and no partial byte resumes.
- FIFO:
  - Entry is {LAST, ODD & LAST, DATA}, 18 bits.
  - Write on ENA & !FULL. ENA & FULL drops the word and sets OVERFLOW, which is cleared only by RST.
  - Simultaneous write and read when full is not a write; it is still an overflow.
  - FULL and BUSY are registered from count and state.
- FSM: IDLE -> FETCH -> SHIFT -> GAP -> (SHIFT | FETCH | IDLE).
  - IDLE: TX_DATA=0. If FIFO is not empty, go to FETCH.
  - FETCH (1 cycle): pop the FIFO head into a 16-bit shift register plus the last/odd flags; set byte_idx=0; go to SHIFT.
  - SHIFT: 8 cycles, TX_DATA = sreg[15], shifting left each cycle.
    - On bit 7: TX_LOAD=1. TX_STOP=1 if this is the final byte of the message, i.e. last & (odd ? byte_idx==0 : byte_idx==1).
  - After SHIFT:
    - If GAP_CYCLES=0, skip GAP.
    - Otherwise GAP holds TX_DATA=0 for GAP_CYCLES cycles.
  - After GAP:
    - If byte_idx==0 and the word is not odd-last: byte_idx=1, return to SHIFT.
    - Else, if FIFO is non-empty: FETCH.
    - Else: IDLE.
- Latency: first TX_DATA bit appears 2 cycles after the ENA that writes into an empty FIFO while IDLE. That is 1 cycle to the FIFO write plus the FETCH cycle.
- A non-LAST word with ODD=1 ignores ODD; both bytes are sent.
- A message longer than the FIFO streams without gaps beyond GAP_CYCLES, provided the writer keeps ahead.
- BUSY falls in the cycle after the last GAP cycle when the FIFO is empty.

Optional Feature:
- SPI_TX_PARITY_EN defined:
  - Each byte is followed by an odd-parity bit (~^byte), so SHIFT lasts 9 cycles.
  - TX_LOAD and TX_STOP move to the parity bit.
- Undefined: 8-bit bytes, no parity; behaviour exactly as above.

Decomposition:
- Shared package/defines hold:
  - FSM state encodings S_IDLE/S_FETCH/S_SHIFT/S_GAP.
  - BITS_PER_BYTE (8, or 9 under SPI_TX_PARITY_EN).
  - FIFO entry field positions (LAST_BIT=17, ODD_BIT=16).
- One sub-module, tx_word_fifo: synchronous FIFO with width 18 and depth 2**FIFO_AW, exposing full/empty/count. The FSM and shifter stay in the top.

Test Plan:
- Reset state: assert RST mid-SHIFT of word 0xA5C3 -> next cycle TX_DATA/TX_LOAD/TX_STOP/BUSY=0; after release, with no ENA, the line stays idle.
- Single word: ENA with DATA=0xA5C3, LAST=1, ODD=0, GAP=2.
  - TX_DATA = 1,0,1,0,0,1,0,1, then 0,0, then 1,1,0,0,0,0,1,1.
  - TX_LOAD on bits 8 and 18; TX_STOP only on bit 18.
  - BUSY drops 2 cycles later.
- Odd last: 0x1234 (LAST=0) then 0x5600 (LAST=1, ODD=1) -> three bytes 12,34,56; TX_STOP on the final bit of 0x56 only; the 0x00 byte is never sent.
- Overflow, FIFO_AW=2: 6 back-to-back ENA while the shifter is busy -> FULL after the 4th stored word (1st word already popped); the 6th is dropped; OVERFLOW=1 and stays 1; the stored words are sent in order.
- GAP_CYCLES=0: two words sent back-to-back -> 32 contiguous bit-times plus 1 FETCH idle cycle between words.
- SPI_TX_PARITY_EN: byte 0x07 -> 9 bits 0,0,0,0,0,1,1,1,0 (three ones, so parity bit is 0); TX_LOAD on the 9th bit.

Source files
------------

// File: rtl/spi_tx_serializer_pkg.sv
// Shared types and constants for the SPI transmit serializer.
// Build option: define SPI_TX_PARITY_EN to append an odd-parity bit to every byte.
package spi_tx_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

`ifdef SPI_TX_PARITY_EN
    localparam int BITS_PER_BYTE = 9;
`else
    localparam int BITS_PER_BYTE = 8;
`endif

    localparam int ENTRY_W  = 18;
    localparam int LAST_BIT = 17;
    localparam int ODD_BIT  = 16;

    // ODD only has meaning on the final word of a message.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [15:0] data,
                                                      input logic        last,
                                                      input logic        odd);
        return {last, odd & last, data};
    endfunction

endpackage

// File: rtl/spi_tx_serializer_word_fifo.sv
// Synchronous word FIFO feeding the serializer; depth 2**AW, registered full/empty/count.
// The head entry is read combinationally so FETCH can pop a word written on the previous edge.
module tx_word_fifo #(
    parameter int AW = 4,
    parameter int W  = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          do_wr;
    logic          do_rd;

    // A write while full is refused even if a pop happens on the same edge.
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/spi_tx_serializer.sv
// SPI transmit serializer: buffers 16-bit FD words and shifts them out MSB-first with byte/message markers.
// Build option: SPI_TX_PARITY_EN adds an odd-parity bit after each byte (markers move onto it).
module spi_tx_serializer
    import spi_tx_serializer_pkg::*;
#(
    parameter int FIFO_AW    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        ENA,
    input  logic        LAST,
    input  logic        ODD,
    output logic        TX_DATA,
    output logic        TX_LOAD,
    output logic        TX_STOP,
    output logic        BUSY,
    output logic        FULL,
    output logic        OVERFLOW
);
    localparam logic [3:0] LAST_IDX = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0] MARK_IDX = 4'(BITS_PER_BYTE - 2);
    localparam logic [3:0] GAP_IDX  = 4'(GAP_CYCLES - 1);

    state_t             state;
    logic [15:0]        sreg;
    logic               last_reg;
    logic               odd_reg;
    logic               byte_idx;
    logic [3:0]         bit_cnt;
    logic [3:0]         gap_cnt;
`ifdef SPI_TX_PARITY_EN
    logic               parity_bit;
`endif

    logic [ENTRY_W-1:0] head;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_count;
    logic               wr_ok;
    logic               byte_end;
    logic               byte_done;
    logic               final_byte;
    logic               more_bytes;

    tx_word_fifo #(
        .AW (FIFO_AW),
        .W  (ENTRY_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (ENA),
        .wr_data (pack_entry(DATA, LAST, ODD)),
        .rd_en   (state == S_FETCH),
        .rd_data (head),
        .full    (FULL),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign wr_ok      = ENA & ~FULL;
    assign byte_end   = (state == S_SHIFT) && (bit_cnt == LAST_IDX);
    assign byte_done  = (GAP_CYCLES == 0) ? byte_end
                                          : ((state == S_GAP) && (gap_cnt == GAP_IDX));
    assign final_byte = last_reg & (odd_reg ? (byte_idx == 1'b0) : (byte_idx == 1'b1));
    assign more_bytes = (byte_idx == 1'b0) && !(last_reg && odd_reg);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            sreg       <= '0;
            last_reg   <= 1'b0;
            odd_reg    <= 1'b0;
            byte_idx   <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
`ifdef SPI_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            TX_DATA    <= 1'b0;
            TX_LOAD    <= 1'b0;
            TX_STOP    <= 1'b0;
            BUSY       <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (ENA && FULL) begin
                OVERFLOW <= 1'b1;
            end
            TX_DATA <= 1'b0;
            TX_LOAD <= 1'b0;
            TX_STOP <= 1'b0;
            BUSY    <= 1'b1;

            case (state)
                S_IDLE: begin
                    // Looking at the incoming write saves a cycle of first-bit latency.
                    if ((fifo_count != '0) || wr_ok) begin
                        state <= S_FETCH;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                S_FETCH: begin
                    sreg     <= {head[14:0], 1'b0};
                    TX_DATA  <= head[15];
                    last_reg <= head[LAST_BIT];
                    odd_reg  <= head[ODD_BIT];
                    byte_idx <= 1'b0;
                    bit_cnt  <= '0;
`ifdef SPI_TX_PARITY_EN
                    parity_bit <= ~^head[15:8];
`endif
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!byte_end) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == MARK_IDX) begin
                            TX_LOAD <= 1'b1;
                            TX_STOP <= final_byte;
                        end
`ifdef SPI_TX_PARITY_EN
                        if (bit_cnt == 4'd7) begin
                            TX_DATA <= parity_bit;
                        end else begin
                            TX_DATA <= sreg[15];
                            sreg    <= {sreg[14:0], 1'b0};
                        end
`else
                        TX_DATA <= sreg[15];
                        sreg    <= {sreg[14:0], 1'b0};
`endif
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // End of a byte (after its gap, if any) decides what the line does next.
            if (byte_done) begin
                if (more_bytes) begin
                    byte_idx <= 1'b1;
                    bit_cnt  <= '0;
                    TX_DATA  <= sreg[15];
                    sreg     <= {sreg[14:0], 1'b0};
`ifdef SPI_TX_PARITY_EN
                    parity_bit <= ~^sreg[15:8];
`endif
                    state    <= S_SHIFT;
                end else if (!fifo_empty) begin
                    state <= S_FETCH;
                end else begin
                    state <= S_IDLE;
                    BUSY  <= wr_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Self-checking bench for spi_tx_serializer: two instances (deep FIFO with gaps, shallow FIFO without gaps)
// driven with word bursts and compared cycle by cycle against a per-bit reference trace.
module tb_spi_tx_serializer;

    localparam int AW_A  = 4;
    localparam int GAP_A = 2;
    localparam int AW_B  = 2;
    localparam int GAP_B = 0;
`ifdef SPI_TX_PARITY_EN
    localparam int BITS = 9;
`else
    localparam int BITS = 8;
`endif

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        o;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic        ena_a = 1'b0;
    logic        ena_b = 1'b0;
    logic        last = 1'b0;
    logic        odd = 1'b0;

    logic a_tx, a_ld, a_st, a_busy, a_full, a_ovf;
    logic b_tx, b_ld, b_st, b_busy, b_full, b_ovf;

    int compared = 0;
    int mismatched = 0;

    word_t      words[$];
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    logic       full_seen[$];
    logic       ovf_seen[$];

    always #5 clk = ~clk;

    spi_tx_serializer #(.FIFO_AW(AW_A), .GAP_CYCLES(GAP_A)) u_a (
        .CLK(clk), .RST(rst), .DATA(data), .ENA(ena_a), .LAST(last), .ODD(odd),
        .TX_DATA(a_tx), .TX_LOAD(a_ld), .TX_STOP(a_st), .BUSY(a_busy), .FULL(a_full), .OVERFLOW(a_ovf)
    );

    spi_tx_serializer #(.FIFO_AW(AW_B), .GAP_CYCLES(GAP_B)) u_b (
        .CLK(clk), .RST(rst), .DATA(data), .ENA(ena_b), .LAST(last), .ODD(odd),
        .TX_DATA(b_tx), .TX_LOAD(b_ld), .TX_STOP(b_st), .BUSY(b_busy), .FULL(b_full), .OVERFLOW(b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {b_busy, b_tx, b_ld, b_st} : {a_busy, a_tx, a_ld, a_st};
    endfunction

    // Reference: each accepted word costs one fetch cycle, then its bytes MSB-first, each followed by the gap.
    task automatic build_trace(input int gap, input int acc);
        logic [15:0] w;
        logic [7:0]  by;
        logic        bt, ld, st, lst;
        int          nb;
        exp_q.delete();
        for (int k = 0; k < acc; k++) begin
            w   = words[k].d;
            lst = words[k].l;
            nb  = (words[k].l && words[k].o) ? 1 : 2;
            exp_q.push_back(4'b1000);
            for (int b = 0; b < nb; b++) begin
                by = (b == 0) ? w[15:8] : w[7:0];
                for (int i = 0; i < BITS; i++) begin
                    bt = (i < 8) ? by[7 - i] : ~^by;
                    ld = (i == BITS - 1);
                    st = ld && lst && (b == nb - 1);
                    exp_q.push_back({1'b1, bt, ld, st});
                end
                for (int g = 0; g < gap; g++) exp_q.push_back(4'b1000);
            end
        end
        repeat (4) exp_q.push_back(4'b0000);
    endtask

    // Writes all queued words on consecutive cycles into an idle DUT and records its outputs.
    task automatic run_burst(input bit sel, input string name);
        int gap, depth, n, acc;
        gap   = sel ? GAP_B : GAP_A;
        depth = sel ? (2 ** AW_B) : (2 ** AW_A);
        n     = words.size();
        acc   = (n < depth + 1) ? n : depth + 1;
        build_trace(gap, acc);
        obs_q.delete();
        full_seen.delete();
        ovf_seen.delete();
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c < n) begin
                data = words[c].d;
                last = words[c].l;
                odd  = words[c].o;
                if (sel) ena_b = 1'b1; else ena_a = 1'b1;
            end else begin
                ena_a = 1'b0;
                ena_b = 1'b0;
                data  = '0;
                last  = 1'b0;
                odd   = 1'b0;
            end
            tick();
            obs_q.push_back(obs(sel));
            full_seen.push_back(sel ? b_full : a_full);
            ovf_seen.push_back(sel ? b_ovf : a_ovf);
        end
        $display("burst %s: dut %s, %0d words written, %0d expected on the line, %0d cycles",
                 name, sel ? "b" : "a", n, acc, exp_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        compared++;
        if ({a_tx, a_ld, a_st, a_busy, a_full, a_ovf} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_a: outputs %b, required 000000", {a_tx, a_ld, a_st, a_busy, a_full, a_ovf});
        end
        compared++;
        if ({b_tx, b_ld, b_st, b_busy, b_full, b_ovf} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_b: outputs %b, required 000000", {b_tx, b_ld, b_st, b_busy, b_full, b_ovf});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        data = 16'hA5C3; last = 1'b1; odd = 1'b0; ena_a = 1'b1;
        tick();
        ena_a = 1'b0; data = '0; last = 1'b0;
        repeat (4) tick();
        compared++;
        if (a_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_shift_busy: BUSY %b, required 1", a_busy);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({a_tx, a_ld, a_st, a_busy} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_async: tx/load/stop/busy %b, required 0000", {a_tx, a_ld, a_st, a_busy});
        end
        tick();
        compared++;
        if ({a_tx, a_ld, a_st, a_busy} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_next_cycle: tx/load/stop/busy %b, required 0000", {a_tx, a_ld, a_st, a_busy});
        end
        rst = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick();
            compared++;
            if ({a_tx, a_ld, a_st, a_busy, a_full, a_ovf} !== 6'b0) begin
                mismatched++;
                $display("FAIL post_reset_idle cycle %0d: outputs %b, required 000000",
                         c, {a_tx, a_ld, a_st, a_busy, a_full, a_ovf});
            end
        end
        $display("reset mid-shift of 0xA5C3 checked");
    endtask

    task automatic test_single_word();
        words.delete();
        words.push_back('{d: 16'hA5C3, l: 1'b1, o: 1'b0});
        run_burst(1'b0, "single_word");
        for (int c = 0; c < exp_q.size(); c++) begin
            compared++;
            if (obs_q[c] !== exp_q[c]) begin
                mismatched++;
                $display("FAIL single_word cycle %0d: busy/data/load/stop %b, required %b", c + 1, obs_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_odd_last();
        words.delete();
        words.push_back('{d: 16'h1234, l: 1'b0, o: 1'b0});
        words.push_back('{d: 16'h5600, l: 1'b1, o: 1'b1});
        run_burst(1'b0, "odd_last");
        for (int c = 0; c < exp_q.size(); c++) begin
            compared++;
            if (obs_q[c] !== exp_q[c]) begin
                mismatched++;
                $display("FAIL odd_last cycle %0d: busy/data/load/stop %b, required %b", c + 1, obs_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_odd_ignored();
        words.delete();
        words.push_back('{d: 16'hBEEF, l: 1'b0, o: 1'b1});
        words.push_back('{d: 16'h0181, l: 1'b1, o: 1'b0});
        run_burst(1'b0, "odd_not_last");
        for (int c = 0; c < exp_q.size(); c++) begin
            compared++;
            if (obs_q[c] !== exp_q[c]) begin
                mismatched++;
                $display("FAIL odd_not_last cycle %0d: busy/data/load/stop %b, required %b", c + 1, obs_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_overflow();
        words.delete();
        for (int k = 0; k < 6; k++) begin
            words.push_back('{d: 16'($urandom), l: (k == 4), o: 1'b0});
        end
        run_burst(1'b1, "overflow");
        for (int c = 0; c < exp_q.size(); c++) begin
            compared++;
            if (obs_q[c] !== exp_q[c]) begin
                mismatched++;
                $display("FAIL overflow_stream cycle %0d: busy/data/load/stop %b, required %b", c + 1, obs_q[c], exp_q[c]);
            end
        end
        // Word 0 is popped one cycle after its write, so words 1..4 fill the 4-deep FIFO.
        compared++;
        if (full_seen[3] !== 1'b0) begin
            mismatched++;
            $display("FAIL full_before_4th: FULL %b, required 0", full_seen[3]);
        end
        compared++;
        if (full_seen[4] !== 1'b1) begin
            mismatched++;
            $display("FAIL full_after_4th: FULL %b, required 1", full_seen[4]);
        end
        compared++;
        if (ovf_seen[4] !== 1'b0) begin
            mismatched++;
            $display("FAIL overflow_early: OVERFLOW %b, required 0", ovf_seen[4]);
        end
        compared++;
        if (ovf_seen[5] !== 1'b1) begin
            mismatched++;
            $display("FAIL overflow_set: OVERFLOW %b, required 1", ovf_seen[5]);
        end
        compared++;
        if ({b_ovf, b_full} !== 2'b10) begin
            mismatched++;
            $display("FAIL overflow_sticky: OVERFLOW/FULL %b, required 10", {b_ovf, b_full});
        end
    endtask

    task automatic test_gap0();
        words.delete();
        words.push_back('{d: 16'hF00F, l: 1'b0, o: 1'b0});
        words.push_back('{d: 16'h3CA5, l: 1'b1, o: 1'b0});
        run_burst(1'b1, "gap0_back_to_back");
        for (int c = 0; c < exp_q.size(); c++) begin
            compared++;
            if (obs_q[c] !== exp_q[c]) begin
                mismatched++;
                $display("FAIL gap0 cycle %0d: busy/data/load/stop %b, required %b", c + 1, obs_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        bit sel;
        for (int r = 0; r < 12; r++) begin
            sel = r[0];
            n   = sel ? $urandom_range(1, 5) : $urandom_range(1, 6);
            words.delete();
            for (int k = 0; k < n; k++) begin
                words.push_back('{d: 16'($urandom), l: 1'($urandom), o: 1'($urandom)});
            end
            run_burst(sel, "random");
            for (int c = 0; c < exp_q.size(); c++) begin
                compared++;
                if (obs_q[c] !== exp_q[c]) begin
                    mismatched++;
                    $display("FAIL random round %0d cycle %0d: busy/data/load/stop %b, required %b",
                             r, c + 1, obs_q[c], exp_q[c]);
                end
            end
        end
    endtask

`ifdef SPI_TX_PARITY_EN
    task automatic test_parity();
        words.delete();
        words.push_back('{d: 16'h0700, l: 1'b1, o: 1'b1});
        run_burst(1'b0, "parity");
        for (int c = 0; c < exp_q.size(); c++) begin
            compared++;
            if (obs_q[c] !== exp_q[c]) begin
                mismatched++;
                $display("FAIL parity cycle %0d: busy/data/load/stop %b, required %b", c + 1, obs_q[c], exp_q[c]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_reset_mid_shift();
        test_odd_last();
        test_odd_ignored();
        test_overflow();
        test_gap0();
`ifdef SPI_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
